gate_stimulus_checker: RTL

- Upstream/downstream companion for the 2-input gate modules in the codebase, such as nand_gate.
- Drives a gate's a/b inputs through all four input combinations, waits a settle time, samples the gate's y, and compares it against a parameterised truth table.
- Reports busy/done, pass/fail, a saturating error count and the first failing vector.
- Replaces hand-written #delay stimulus with a synthesizable, clocked self-check usable on hardware.

---
 rtl/gate_check_pkg.sv | 27 ++
 rtl/gate_settle_timer.sv | 34 +++
 rtl/gate_stimulus_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gate_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_check_pkg
// Purpose  : Shared state encoding and 2-input gate truth tables used by the
//            gate stimulus checker. Truth tables are indexed by {a,b}.
// Revision : 1.0  initial release
// ============================================================================
package gate_check_pkg;

  // Checker FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected y for {a,b} = 11,10,01,00 (bit3..bit0)
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage
`default_nettype wire

// File: rtl/gate_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : gate_settle_timer
// Purpose  : Loadable down-counter. expired is high whenever the count is
//            zero, so loading N gives N+1 cycles before expiry.
// Revision : 1.0  initial release
// ============================================================================
module gate_settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_stimulus_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_stimulus_checker
// Purpose  : Sweeps a 2-input gate through {a,b} = 00,01,10,11 for LOOPS
//            passes, holds each vector SETTLE_CYCLES cycles, samples y for
//            one cycle and scores it against TRUTH. Reports busy/done,
//            pass, a saturating error count and the first failing vector.
// Revision : 1.0  initial release
// ============================================================================
module gate_stimulus_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TRUTH         = TT_NAND,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 1,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX     = {CNT_W{1'b1}};

  state_t            r_state;
  logic [1:0]        r_vec;
  logic [LOOP_W-1:0] r_loop;

  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_next;
  logic             w_timer_load;
  logic             w_settle_done;

  // Scoreboard: y is only meaningful in SAMPLE, the FSM gates its use
  assign w_mismatch = (y_in != TRUTH[r_vec]);
  assign w_err_next = (w_mismatch && (err_count != ERR_MAX)) ?
                      err_count + CNT_W'(1) : err_count;

  // Re-arm the dwell timer whenever a new vector is about to be driven
  assign w_timer_load = ((r_state == ST_IDLE) && start) || (r_state == ST_SAMPLE);

  gate_settle_timer #(
    .WIDTH (SET_W)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .load    (w_timer_load),
    .value   (SETTLE_LOAD),
    .expired (w_settle_done)
  );

  // Sequencer FSM with registered stimulus, status and scoreboard outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_loop     <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          a_out <= 1'b0;
          b_out <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            pass       <= 1'b0;
            r_vec      <= '0;
            r_loop     <= '0;
            busy       <= 1'b1;
            r_state    <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (w_settle_done) begin
            r_state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          err_count <= w_err_next;
          if (w_mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= r_vec;
          end
          if (r_vec == 2'd3) begin
            if (r_loop == LOOP_LAST) begin
              // pass uses the post-update count so it is valid with done
              done    <= 1'b1;
              busy    <= 1'b0;
              a_out   <= 1'b0;
              b_out   <= 1'b0;
              pass    <= (w_err_next == '0);
              r_state <= ST_DONE;
            end else begin
              r_vec          <= 2'd0;
              r_loop         <= r_loop + LOOP_W'(1);
              {a_out, b_out} <= 2'b00;
              r_state        <= ST_SETTLE;
            end
          end else begin
            r_vec          <= r_vec + 2'd1;
            {a_out, b_out} <= r_vec + 2'd1;
            r_state        <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
